// File: rtl/fanout_pkg.sv
// Shared defaults and types for the eager-fork fanout stage.
package fanout_pkg;
    localparam int NUM_OUT_DEFAULT    = 7;
    localparam int DATA_WIDTH_DEFAULT = 17;
    localparam int CNT_WIDTH_DEFAULT  = 16;

    typedef logic [NUM_OUT_DEFAULT-1:0] dest_mask_t;
endpackage

// File: rtl/fanout_done_tracker.sv
// Tracks which selected destinations have taken the held token and detects retirement.
module fanout_done_tracker
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               full,
    input  logic [NUM_OUT-1:0] active,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic               retire
);
    logic [NUM_OUT-1:0] done_q;
    logic [NUM_OUT-1:0] done_d;
    logic [NUM_OUT-1:0] acc;

    always_comb begin
        out_valid = {NUM_OUT{full}} & active & ~done_q;
        acc       = out_valid & out_ready;
        // Inactive destinations count as already done, so an empty mask retires at once.
        retire    = full & (&(done_q | acc | ~active));
        done_d    = done_q | acc;
        if (retire || flush) begin
            done_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end
endmodule

// File: rtl/fanout_fork.sv
// Registered eager fork: holds one token and offers it to every selected destination.
module fanout_fork
    import fanout_pkg::*;
#(
    parameter int NUM_OUT    = NUM_OUT_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic [NUM_OUT-1:0]    cfg_sel,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [NUM_OUT-1:0]    out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [CNT_WIDTH-1:0]  retired_cnt,
    output logic                  busy
);
    logic                  full_q,   full_d;
    logic [DATA_WIDTH-1:0] data_q,   data_d;
    logic [NUM_OUT-1:0]    active_q, active_d;
    logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
    logic                  retire;
    logic                  load;

    fanout_done_tracker #(
        .NUM_OUT(NUM_OUT)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .full      (full_q),
        .active    (active_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .retire    (retire)
    );

    always_comb begin
        in_ready = ~flush & (~full_q | retire);
        load     = in_valid & in_ready;

        full_d   = full_q;
        data_d   = data_q;
        active_d = active_q;
        cnt_d    = cnt_q;

        if (retire) begin
            full_d = 1'b0;
        end
        // Route mask is captured with the token so later config writes cannot redirect it.
        if (load) begin
            full_d   = 1'b1;
            data_d   = in_data;
            active_d = cfg_en & cfg_sel;
        end
        if (flush) begin
            full_d = 1'b0;
        end
        if (retire && !flush && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            data_q   <= '0;
            active_q <= '0;
            cnt_q    <= '0;
        end else begin
            full_q   <= full_d;
            data_q   <= data_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_data    = data_q;
    assign retired_cnt = cnt_q;
    assign busy        = full_q;
endmodule

// File: tb/tb_fanout_fork.sv
// Directed self-checking bench for fanout_fork (counter narrowed to 4 bits).
module tb_fanout_fork;
    localparam int NO = 7;
    localparam int DW = 17;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NO-1:0] cfg_en, cfg_sel, out_valid, out_ready;
    logic          flush, in_valid, in_ready, busy;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] retired_cnt;

    int checks   = 0;
    int failures = 0;

    fanout_fork #(.NUM_OUT(NO), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .cfg_sel     (cfg_sel),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .retired_cnt (retired_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; cfg_en = '0; cfg_sel = '0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = '0;
        step; step;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cfg_en = '1; cfg_sel = '1; flush = 1'b0;
        in_valid = 1'b1; in_data = 17'h1_2345; out_ready = '1;
        step; settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL rst_out_valid got=%h exp=%h", out_valid, 7'h00); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 17'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (retired_cnt !== 4'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", retired_cnt); end
        do_reset;
    endtask

    task automatic test_single_dest;
        logic [DW-1:0] tok [4];
        tok[0] = 17'h0_1111; tok[1] = 17'h1_2222; tok[2] = 17'h0_3333; tok[3] = 17'h1_4444;
        do_reset;
        cfg_en = 7'h01; cfg_sel = 7'h01; out_ready = 7'h01;
        in_valid = 1'b1; in_data = tok[0];
        settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL single_latency got=%h exp=%h", out_valid, 7'h00); end
        for (int i = 1; i < 4; i++) begin
            step; in_data = tok[i]; settle;
            checks++; if (out_valid !== 7'h01) begin failures++; $display("FAIL single_ov[%0d] got=%h exp=%h", i, out_valid, 7'h01); end
            checks++; if (out_data !== tok[i-1]) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", i, out_data, tok[i-1]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_rdy[%0d] got=%b exp=1", i, in_ready); end
        end
        step; in_valid = 1'b0; settle;
        checks++; if (out_data !== tok[3]) begin failures++; $display("FAIL single_last_data got=%h exp=%h", out_data, tok[3]); end
        step; settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL single_idle_ov got=%h exp=0", out_valid); end
        checks++; if (retired_cnt !== 4'd4) begin failures++; $display("FAIL single_cnt got=%0d exp=4", retired_cnt); end
    endtask

    task automatic test_staggered;
        logic [NO-1:0] rdy_tab [1:6];
        logic [NO-1:0] ov_tab  [1:6];
        logic          ir_tab  [1:6];
        rdy_tab[1] = 7'h01; ov_tab[1] = 7'h07; ir_tab[1] = 1'b0;
        rdy_tab[2] = 7'h00; ov_tab[2] = 7'h06; ir_tab[2] = 1'b0;
        rdy_tab[3] = 7'h02; ov_tab[3] = 7'h06; ir_tab[3] = 1'b0;
        rdy_tab[4] = 7'h00; ov_tab[4] = 7'h04; ir_tab[4] = 1'b0;
        rdy_tab[5] = 7'h04; ov_tab[5] = 7'h04; ir_tab[5] = 1'b1;
        rdy_tab[6] = 7'h00; ov_tab[6] = 7'h00; ir_tab[6] = 1'b1;
        do_reset;
        cfg_en = 7'h7F; cfg_sel = 7'h07;
        in_valid = 1'b1; in_data = 17'h0_ABCD;
        for (int k = 1; k <= 6; k++) begin
            step; in_valid = 1'b0; out_ready = rdy_tab[k]; settle;
            checks++; if (out_valid !== ov_tab[k]) begin failures++; $display("FAIL stag_ov[%0d] got=%h exp=%h", k, out_valid, ov_tab[k]); end
            checks++; if (in_ready !== ir_tab[k]) begin failures++; $display("FAIL stag_rdy[%0d] got=%b exp=%b", k, in_ready, ir_tab[k]); end
        end
        checks++; if (retired_cnt !== 4'd1) begin failures++; $display("FAIL stag_cnt got=%0d exp=1", retired_cnt); end
        out_ready = '0;
    endtask

    task automatic test_cfg_change;
        do_reset;
        cfg_en = 7'h7F; cfg_sel = 7'h03;
        in_valid = 1'b1; in_data = 17'h0_00D0;
        step; cfg_sel = 7'h0C; in_data = 17'h1_00D1; settle;
        checks++; if (out_valid !== 7'h03) begin failures++; $display("FAIL cfg_held_ov got=%h exp=%h", out_valid, 7'h03); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfg_held_rdy got=%b exp=0", in_ready); end
        step; out_ready = 7'h03; settle;
        checks++; if (out_valid !== 7'h03) begin failures++; $display("FAIL cfg_held_ov2 got=%h exp=%h", out_valid, 7'h03); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cfg_retire_rdy got=%b exp=1", in_ready); end
        step; in_valid = 1'b0; out_ready = 7'h00; settle;
        checks++; if (out_valid !== 7'h0C) begin failures++; $display("FAIL cfg_next_ov got=%h exp=%h", out_valid, 7'h0C); end
        checks++; if (out_data !== 17'h1_00D1) begin failures++; $display("FAIL cfg_next_data got=%h exp=%h", out_data, 17'h1_00D1); end
        step; out_ready = 7'h0C; settle;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cfg_next_rdy got=%b exp=1", in_ready); end
        step; out_ready = 7'h00; settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL cfg_idle_ov got=%h exp=0", out_valid); end
        checks++; if (retired_cnt !== 4'd2) begin failures++; $display("FAIL cfg_cnt got=%0d exp=2", retired_cnt); end
    endtask

    task automatic test_empty_mask;
        do_reset;
        cfg_en = 7'h00; cfg_sel = 7'h7F; out_ready = 7'h00;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step;
            in_valid = 1'b1; in_data = 17'(i + 5); settle;
            checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL empty_ov[%0d] got=%h exp=0", i, out_valid); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL empty_rdy[%0d] got=%b exp=1", i, in_ready); end
        end
        step; in_valid = 1'b0; settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL empty_ov_last got=%h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL empty_rdy_last got=%b exp=1", in_ready); end
        step; settle;
        checks++; if (retired_cnt !== 4'd3) begin failures++; $display("FAIL empty_cnt got=%0d exp=3", retired_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy got=%b exp=0", busy); end
    endtask

    task automatic test_flush;
        do_reset;
        cfg_en = 7'h7F; cfg_sel = 7'h03;
        in_valid = 1'b1; in_data = 17'h0_0F00;
        step; in_valid = 1'b0; out_ready = 7'h01; settle;
        checks++; if (out_valid !== 7'h03) begin failures++; $display("FAIL flush_pre_ov got=%h exp=%h", out_valid, 7'h03); end
        step; out_ready = 7'h00; settle;
        checks++; if (out_valid !== 7'h02) begin failures++; $display("FAIL flush_partial_ov got=%h exp=%h", out_valid, 7'h02); end
        step; flush = 1'b1; in_valid = 1'b1; in_data = 17'h1_0F01; settle;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_rdy got=%b exp=0", in_ready); end
        step; flush = 1'b0; in_valid = 1'b0; settle;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL flush_ov got=%h exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
        checks++; if (retired_cnt !== 4'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", retired_cnt); end
        step; in_valid = 1'b1; in_data = 17'h0_0F02; settle;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_next_rdy got=%b exp=1", in_ready); end
        step; in_valid = 1'b0; settle;
        checks++; if (out_valid !== 7'h03) begin failures++; $display("FAIL flush_clean_ov got=%h exp=%h", out_valid, 7'h03); end
        checks++; if (out_data !== 17'h0_0F02) begin failures++; $display("FAIL flush_next_data got=%h exp=%h", out_data, 17'h0_0F02); end
        step; out_ready = 7'h03; settle;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_next_retire got=%b exp=1", in_ready); end
        step; out_ready = 7'h00; settle;
        checks++; if (retired_cnt !== 4'd1) begin failures++; $display("FAIL flush_next_cnt got=%0d exp=1", retired_cnt); end
        // Hold a partially accepted token, then drop rst_n between clock edges.
        step; in_valid = 1'b1; in_data = 17'h1_0F03;
        step; in_valid = 1'b0; out_ready = 7'h01;
        step; out_ready = 7'h00; settle;
        checks++; if (out_valid !== 7'h02) begin failures++; $display("FAIL arst_pre_ov got=%h exp=%h", out_valid, 7'h02); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 7'h00) begin failures++; $display("FAIL arst_ov got=%h exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_rdy got=%b exp=1", in_ready); end
        checks++; if (out_data !== 17'h0) begin failures++; $display("FAIL arst_data got=%h exp=0", out_data); end
        checks++; if (retired_cnt !== 4'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", retired_cnt); end
        step; rst_n = 1'b1;
    endtask

    task automatic test_saturation;
        do_reset;
        cfg_en = 7'h01; cfg_sel = 7'h01; out_ready = 7'h01;
        in_valid = 1'b1; in_data = 17'h0_5A5A;
        for (int i = 1; i <= 20; i++) begin
            step;
            if (i == 20) in_valid = 1'b0;
            settle;
            if (i == 15) begin
                checks++; if (retired_cnt !== 4'd14) begin failures++; $display("FAIL sat_mid_cnt got=%0d exp=14", retired_cnt); end
            end
        end
        step; step; settle;
        checks++; if (retired_cnt !== 4'hF) begin failures++; $display("FAIL sat_cnt got=%h exp=%h", retired_cnt, 4'hF); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_busy got=%b exp=0", busy); end
        out_ready = 7'h00;
    endtask

    initial begin
        test_reset;
        test_single_dest;
        test_staggered;
        test_cfg_change;
        test_empty_mask;
        test_flush;
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
